// File: rtl/adrv9001_spi_pkg.sv
// rtl/adrv9001_spi_pkg.sv - shared types and constants for the ADRV9001 SPI responder
package adrv9001_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_FETCH,
        ST_RD_DATA,
        ST_WR_DATA
    } spi_state_t;

    localparam int CMD_BITS  = 16;
    localparam int DATA_BITS = 8;
    localparam int RNW_BIT   = 23 - 8;

endpackage

// File: rtl/adrv9001_spi_sync_edge.sv
// rtl/adrv9001_spi_sync_edge.sv - N-stage synchronizer with registered rise/fall detect
module adrv9001_spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    logic              r_rise;
    logic              r_fall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
            r_rise <= r_sync[STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[STAGES-1] & r_prev;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/adrv9001_spi_responder.sv
// rtl/adrv9001_spi_responder.sv - oversampled SPI target decoding ADRV9001 register frames
module adrv9001_spi_responder
    import adrv9001_spi_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int ADDR_DESCEND = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              spi_sck_i,
    input  logic              spi_csn_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_t,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic [7:0]        reg_wdata,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              frame_err
);

    localparam logic [3:0]        CMD_LAST  = 4'(CMD_BITS - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    logic w_sck_rise, w_sck_fall, w_csn_rise, w_csn_fall;
    logic w_mosi, w_sck_bit, w_cmd_done, w_byte_done;
    logic [CMD_BITS-1:0]  w_cmd_word;
    logic [7:0]           w_data_byte;
    logic [ADDR_W-1:0]    w_addr_next;

    spi_state_t            r_state, w_next_state;
    logic [SYNC_STAGES:0]  r_mosi_sync;
    logic [3:0]            r_bit_cnt;
    logic [CMD_BITS-2:0]   r_shift;
    logic                  r_rd_pend;
    logic                  r_miso;
    logic [ADDR_W-1:0]     r_addr;
    logic [7:0]            r_wdata;
    logic                  r_wr;
    logic                  r_frame_err;

    // CSN chain resets to "asserted" so a frame cut by reset is ignored until CSN toggles
    adrv9001_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rstn(rstn), .i_d(spi_sck_i), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    adrv9001_spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csn (
        .clk(clk), .rstn(rstn), .i_d(spi_csn_i), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
    );

    // One extra flop keeps MOSI aligned with the registered edge pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_mosi_sync <= '0;
        else       r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-1:0], spi_mosi_i};
    end

    assign w_mosi      = r_mosi_sync[SYNC_STAGES];
    assign w_sck_bit   = w_sck_rise & ~w_csn_rise;
    assign w_cmd_word  = {r_shift, w_mosi};
    assign w_data_byte = {r_shift[6:0], w_mosi};
    assign w_cmd_done  = (r_state == ST_CMD) && w_sck_bit && (r_bit_cnt == CMD_LAST);
    assign w_byte_done = ((r_state == ST_RD_DATA) || (r_state == ST_WR_DATA))
                         && w_sck_bit && (r_bit_cnt == DATA_LAST);
    assign w_addr_next = (ADDR_DESCEND != 0) ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_csn_rise) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (w_csn_fall) w_next_state = ST_CMD;
                ST_CMD:      if (w_cmd_done)
                                 w_next_state = w_cmd_word[RNW_BIT] ? ST_RD_FETCH : ST_WR_DATA;
                ST_RD_FETCH: if (r_rd_pend) w_next_state = ST_RD_DATA;
                ST_RD_DATA:  if (w_byte_done) w_next_state = ST_RD_FETCH;
                default:     w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        reg_rd     = 1'b0;
        spi_miso_t = 1'b1;
        case (r_state)
            ST_RD_FETCH: begin
                reg_rd     = ~r_rd_pend;
                spi_miso_t = 1'b0;
            end
            ST_RD_DATA:  spi_miso_t = 1'b0;
            default:     spi_miso_t = 1'b1;
        endcase
        spi_miso_o = r_miso & ~spi_miso_t;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rd_pend   <= 1'b0;
            r_miso      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_wr) r_addr <= w_addr_next;
            if (w_csn_rise) begin
                r_frame_err <= (r_state != ST_IDLE) && (r_bit_cnt != 4'd0);
                r_bit_cnt   <= '0;
                r_rd_pend   <= 1'b0;
                r_miso      <= 1'b0;
            end else begin
                case (r_state)
                    ST_CMD: if (w_sck_bit) begin
                        r_shift <= w_cmd_word[CMD_BITS-2:0];
                        if (w_cmd_done) begin
                            r_bit_cnt <= '0;
                            r_addr    <= w_cmd_word[ADDR_W-1:0];
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    ST_RD_FETCH: begin
                        // reg_rd was high last cycle, so reg_rdata is valid now
                        r_rd_pend <= ~r_rd_pend;
                        if (r_rd_pend) begin
                            r_shift[7:0] <= reg_rdata;
                            r_miso       <= reg_rdata[7];
                            r_addr       <= w_addr_next;
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_sck_bit) begin
                            r_bit_cnt <= w_byte_done ? 4'd0 : r_bit_cnt + 4'd1;
                        end else if (w_sck_fall && (r_bit_cnt != 4'd0)) begin
                            r_shift[7:0] <= {r_shift[6:0], 1'b0};
                            r_miso       <= r_shift[6];
                        end
                    end
                    ST_WR_DATA: if (w_sck_bit) begin
                        r_shift[7:0] <= w_data_byte;
                        if (w_byte_done) begin
                            r_bit_cnt <= '0;
                            r_wdata   <= w_data_byte;
                            r_wr      <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_bit_cnt <= '0;
                        r_rd_pend <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign reg_addr  = r_addr;
    assign reg_wr    = r_wr;
    assign reg_wdata = r_wdata;
    assign frame_err = r_frame_err;

endmodule
